// File: rtl/oai221_bank_pkg.sv
// Shared definitions for the registered OAI221 lane bank.
// Optional scan chain is enabled by defining OAI221_BANK_SCAN_EN.
package oai221_bank_pkg;

    // Output flop reset value: the gate result for all-zero inputs
    localparam logic ZN_RST = 1'b1;

    // Number of registered gate inputs per lane when the input stage is present
    localparam int unsigned LANE_IN_BITS = 5;

    // Single OAI221 gate: !((c1|c2) & (b1|b2) & a)
    function automatic logic oai221(input logic a, input logic b1, input logic b2,
                                    input logic c1, input logic c2);
        return ~((c1 | c2) & (b1 | b2) & a);
    endfunction

    // Scan chain length for a given bank geometry
    function automatic int unsigned scan_len(input int unsigned width,
                                             input int unsigned stages);
        return (stages == 2) ? (LANE_IN_BITS + 1) * width + 2 : width + 1;
    endfunction

endpackage

// File: rtl/oai221_bank_lane.sv
// One OAI221 lane: optional input register, gate and output flop.
// With OAI221_BANK_SCAN_EN defined, every flop gets a scan mux; the input
// register forms a 5-bit segment (A first) and the output flop a 1-bit segment.
module oai221_lane
    import oai221_bank_pkg::*;
#(
    parameter int unsigned STAGES = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic a_i,
    input  logic b1_i,
    input  logic b2_i,
    input  logic c1_i,
    input  logic c2_i,
`ifdef OAI221_BANK_SCAN_EN
    input  logic se_i,
    input  logic in_si_i,
    output logic in_so_o,
    input  logic zn_si_i,
`endif
    output logic zn_o
);

    // Gate operands, bit order {c2, c1, b2, b1, a}
    logic [LANE_IN_BITS-1:0] gate_in;
    logic                    zn_q;

    if (STAGES == 2) begin : g_in_reg
        logic [LANE_IN_BITS-1:0] in_q;

        // Input register; during shift A takes SI and C2 is the segment tail
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                in_q <= '0;
`ifdef OAI221_BANK_SCAN_EN
            end else if (se_i) begin
                in_q <= {in_q[LANE_IN_BITS-2:0], in_si_i};
`endif
            end else if (en_i) begin
                in_q <= {c2_i, c1_i, b2_i, b1_i, a_i};
            end
        end

        assign gate_in = in_q;
`ifdef OAI221_BANK_SCAN_EN
        assign in_so_o = in_q[LANE_IN_BITS-1];
`endif
    end else begin : g_no_in_reg
        assign gate_in = {c2_i, c1_i, b2_i, b1_i, a_i};
`ifdef OAI221_BANK_SCAN_EN
        // No input flops: the input segment is empty
        assign in_so_o = in_si_i;
`endif
    end

    // Output flop captures the gate result; scan shift wins over enable
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            zn_q <= ZN_RST;
`ifdef OAI221_BANK_SCAN_EN
        end else if (se_i) begin
            zn_q <= zn_si_i;
`endif
        end else if (en_i) begin
            zn_q <= oai221(gate_in[0], gate_in[1], gate_in[2], gate_in[3], gate_in[4]);
        end
    end

    assign zn_o = zn_q;

endmodule

// File: rtl/oai221_bank.sv
// Registered bank of WIDTH OAI221 lanes with STAGES (1 or 2) register depth,
// a valid qualifier that travels alongside the data, and a global stall enable.
// Define OAI221_BANK_SCAN_EN to add the SE/SI/SO mux-scan chain.
module oai221_bank
    import oai221_bank_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 1
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             EN,
    input  logic             VLD_I,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B1,
    input  logic [WIDTH-1:0] B2,
    input  logic [WIDTH-1:0] C1,
    input  logic [WIDTH-1:0] C2,
`ifdef OAI221_BANK_SCAN_EN
    input  logic             SE,
    input  logic             SI,
    output logic             SO,
`endif
    output logic [WIDTH-1:0] ZN,
    output logic             VLD_O
);

    if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
        $error("oai221_bank: STAGES must be 1 or 2");
    end
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("oai221_bank: WIDTH must be in 1..64");
    end

    // Valid as seen by the output stage: VLD_I directly, or the registered copy
    logic vld_stage;
    logic vld_o_q;

`ifdef OAI221_BANK_SCAN_EN
    // in_chain walks the input-register segments lane by lane; zn_chain walks ZN
    logic [WIDTH:0] in_chain;
    logic [WIDTH:0] zn_chain;

    assign in_chain[0] = SI;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        oai221_lane #(
            .STAGES (STAGES)
        ) u_lane (
            .clk_i   (CK),
            .rst_ni  (RN),
            .en_i    (EN),
            .a_i     (A[i]),
            .b1_i    (B1[i]),
            .b2_i    (B2[i]),
            .c1_i    (C1[i]),
            .c2_i    (C2[i]),
`ifdef OAI221_BANK_SCAN_EN
            .se_i    (SE),
            .in_si_i (in_chain[i]),
            .in_so_o (in_chain[i+1]),
            .zn_si_i (zn_chain[i]),
`endif
            .zn_o    (ZN[i])
        );
`ifdef OAI221_BANK_SCAN_EN
        assign zn_chain[i+1] = ZN[i];
`endif
    end

    if (STAGES == 2) begin : g_vld_in
        logic vld_in_q;

        // Input-stage valid flop, sits between the input segments and ZN[0]
        always_ff @(posedge CK or negedge RN) begin
            if (!RN) begin
                vld_in_q <= 1'b0;
`ifdef OAI221_BANK_SCAN_EN
            end else if (SE) begin
                vld_in_q <= in_chain[WIDTH];
`endif
            end else if (EN) begin
                vld_in_q <= VLD_I;
            end
        end

        assign vld_stage = vld_in_q;
`ifdef OAI221_BANK_SCAN_EN
        assign zn_chain[0] = vld_in_q;
`endif
    end else begin : g_vld_direct
        assign vld_stage = VLD_I;
`ifdef OAI221_BANK_SCAN_EN
        assign zn_chain[0] = in_chain[WIDTH];
`endif
    end

    // Output valid flop; holds through stalls, tail of the scan chain
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            vld_o_q <= 1'b0;
`ifdef OAI221_BANK_SCAN_EN
        end else if (SE) begin
            vld_o_q <= zn_chain[WIDTH];
`endif
        end else if (EN) begin
            vld_o_q <= vld_stage;
        end
    end

    assign VLD_O = vld_o_q;
`ifdef OAI221_BANK_SCAN_EN
    assign SO = vld_o_q;
`endif

endmodule
